// File: rtl/inst_fifo_pkg.sv
// Shared constants for the dual-issue instruction queue.
// Holds the default geometry, derived pointer/count widths and a width helper.
package inst_fifo_pkg;

    localparam int DEFAULT_DEPTH  = 16;
    localparam int DEFAULT_PC_W   = 32;
    localparam int DEFAULT_INST_W = 32;

    // Derived widths for the default geometry
    localparam int PTR_W  = $clog2(DEFAULT_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    // Width of the optional stall-cycle performance counter
    localparam int PERF_W = 32;

    // Pointer width for an arbitrary power-of-two depth
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/inst_fifo_if.sv
// Fetch/issue-facing bundle of the instruction queue.
// master: the fetch/issue side that pushes and pops; slave: the queue itself.
interface inst_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Push side (fetch)
    logic              wr_en0;
    logic              wr_en1;
    logic [PC_W-1:0]   wr_pc0;
    logic [INST_W-1:0] wr_inst0;
    logic [PC_W-1:0]   wr_pc1;
    logic [INST_W-1:0] wr_inst1;

    // Pop side (issue)
    logic              rd_en0;
    logic              rd_en1;
    logic              rd_valid0;
    logic [PC_W-1:0]   rd_pc0;
    logic [INST_W-1:0] rd_inst0;
    logic              rd_valid1;
    logic [PC_W-1:0]   rd_pc1;
    logic [INST_W-1:0] rd_inst1;

    // Status towards fetch and the pipeline controller
    logic              fifo_stall_req;
    logic [CNT_W-1:0]  count;

    modport master (
        output wr_en0, wr_en1, wr_pc0, wr_inst0, wr_pc1, wr_inst1,
        output rd_en0, rd_en1,
        input  rd_valid0, rd_pc0, rd_inst0, rd_valid1, rd_pc1, rd_inst1,
        input  fifo_stall_req, count
    );

    modport slave (
        input  wr_en0, wr_en1, wr_pc0, wr_inst0, wr_pc1, wr_inst1,
        input  rd_en0, rd_en1,
        output rd_valid0, rd_pc0, rd_inst0, rd_valid1, rd_pc1, rd_inst1,
        output fifo_stall_req, count
    );

endinterface

// File: rtl/inst_fifo_ram.sv
// Entry storage for the instruction queue: DEPTH x {pc, inst}.
// Two write ports (tail, tail+1) and two combinational read ports (head, head+1).
// Data is deliberately not reset; validity is tracked by the occupancy count.
module inst_fifo_ram
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int PC_W   = DEFAULT_PC_W,
    parameter int INST_W = DEFAULT_INST_W
) (
    input  logic                        clk,
    input  logic                        we0,
    input  logic [ptr_width(DEPTH)-1:0] waddr0,
    input  logic [PC_W-1:0]             wpc0,
    input  logic [INST_W-1:0]           winst0,
    input  logic                        we1,
    input  logic [ptr_width(DEPTH)-1:0] waddr1,
    input  logic [PC_W-1:0]             wpc1,
    input  logic [INST_W-1:0]           winst1,
    input  logic [ptr_width(DEPTH)-1:0] raddr0,
    output logic [PC_W-1:0]             rpc0,
    output logic [INST_W-1:0]           rinst0,
    input  logic [ptr_width(DEPTH)-1:0] raddr1,
    output logic [PC_W-1:0]             rpc1,
    output logic [INST_W-1:0]           rinst1
);

    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];

    // Write both slots; the queue guarantees waddr0 != waddr1 when both fire
    always_ff @(posedge clk) begin
        if (we0) begin
            mem_pc[waddr0]   <= wpc0;
            mem_inst[waddr0] <= winst0;
        end
        if (we1) begin
            mem_pc[waddr1]   <= wpc1;
            mem_inst[waddr1] <= winst1;
        end
    end

    assign rpc0   = mem_pc[raddr0];
    assign rinst0 = mem_inst[raddr0];
    assign rpc1   = mem_pc[raddr1];
    assign rinst1 = mem_inst[raddr1];

endmodule

// File: rtl/inst_fifo.sv
// Dual-issue instruction queue between fetch and issue.
// Fetch pushes up to two {pc, inst} pairs per cycle, issue pops up to two from
// a show-ahead head. fifo_flush discards everything (wrong-path recovery).
// Optional build macro INST_FIFO_PERF_CNT_EN adds a saturating stall_cycles
// counter port.
module inst_fifo
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int PC_W   = DEFAULT_PC_W,
    parameter int INST_W = DEFAULT_INST_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              fifo_flush,
    inst_fifo_if.slave        bus
`ifdef INST_FIFO_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cycles
`endif
);

    localparam int ADDR_W = ptr_width(DEPTH);
    localparam int OCC_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [OCC_W-1:0]  occ;

    logic              valid0;
    logic              valid1;
    logic              stall;
    logic              wr_acc0;
    logic              wr_acc1;
    logic              rd_acc0;
    logic              rd_acc1;
    logic [1:0]        n_wr;
    logic [1:0]        n_rd;
    logic [ADDR_W-1:0] head_nxt1;
    logic [ADDR_W-1:0] tail_nxt1;

    // Status is derived from the registered count only, never from this
    // cycle's requests, so fetch sees a clean registered-timing stall.
    assign valid0 = (occ != '0);
    assign valid1 = (occ > OCC_W'(1));
    assign stall  = (occ > OCC_W'(DEPTH - 2));

    // Space freed by same-cycle pops is not reused for same-cycle pushes.
    // A flush discards the writes, so the storage is not touched either.
    assign wr_acc0 = bus.wr_en0 && !stall && !fifo_flush;
    assign wr_acc1 = bus.wr_en0 && bus.wr_en1 && !stall && !fifo_flush;
    assign rd_acc0 = bus.rd_en0 && valid0;
    assign rd_acc1 = bus.rd_en0 && bus.rd_en1 && valid0 && valid1;

    assign n_wr = {1'b0, wr_acc0} + {1'b0, wr_acc1};
    assign n_rd = {1'b0, rd_acc0} + {1'b0, rd_acc1};

    // Second slot addresses wrap naturally modulo DEPTH
    assign head_nxt1 = head + ADDR_W'(1);
    assign tail_nxt1 = tail + ADDR_W'(1);

    // Pointer and occupancy update; flush overrides any same-cycle traffic
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (fifo_flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            head <= head + ADDR_W'(n_rd);
            tail <= tail + ADDR_W'(n_wr);
            occ  <= occ + OCC_W'(n_wr) - OCC_W'(n_rd);
        end
    end

    inst_fifo_ram #(
        .DEPTH  (DEPTH),
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_ram (
        .clk    (clk),
        .we0    (wr_acc0),
        .waddr0 (tail),
        .wpc0   (bus.wr_pc0),
        .winst0 (bus.wr_inst0),
        .we1    (wr_acc1),
        .waddr1 (tail_nxt1),
        .wpc1   (bus.wr_pc1),
        .winst1 (bus.wr_inst1),
        .raddr0 (head),
        .rpc0   (bus.rd_pc0),
        .rinst0 (bus.rd_inst0),
        .raddr1 (head_nxt1),
        .rpc1   (bus.rd_pc1),
        .rinst1 (bus.rd_inst1)
    );

    assign bus.rd_valid0      = valid0;
    assign bus.rd_valid1      = valid1;
    assign bus.fifo_stall_req = stall;
    assign bus.count          = occ;

`ifdef INST_FIFO_PERF_CNT_EN
    // Saturating count of stalled cycles; survives flushes, cleared by reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end
`else
    // Performance counter not built; stall status is still on fifo_stall_req.
`endif

`ifndef SYNTHESIS
    // Flag slot-1 requests without slot 0; the datapath simply ignores them
    always @(posedge clk) begin
        if (resetn) begin
            assert (!(bus.wr_en1 && !bus.wr_en0))
                else $warning("inst_fifo: wr_en1 without wr_en0 is ignored");
            assert (!(bus.rd_en1 && !bus.rd_en0))
                else $warning("inst_fifo: rd_en1 without rd_en0 is ignored");
        end
    end
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_inst_fifo;

    localparam int DEPTH  = 16;
    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic fifo_flush = 1'b0;

    always #5 clk = ~clk;

    inst_fifo_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) bus ();

`ifdef INST_FIFO_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    inst_fifo #(
        .DEPTH  (DEPTH),
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .fifo_flush (fifo_flush),
        .bus        (bus)
`ifdef INST_FIFO_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ent_t;

    ent_t   mq[$];
    longint m_stall = 0;
    int     errors = 0;
    int     checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs required by the queue model after the most recent edge
    task automatic compare_model();
        int n;
        n = mq.size();
        check("m_count", 64'(bus.count), 64'(n));
        check("m_rd_valid0", 64'(bus.rd_valid0), 64'(n >= 1));
        check("m_rd_valid1", 64'(bus.rd_valid1), 64'(n >= 2));
        check("m_stall", 64'(bus.fifo_stall_req), 64'((DEPTH - n) < 2));
        if (n >= 1) begin
            check("m_rd_pc0", 64'(bus.rd_pc0), 64'(mq[0].pc));
            check("m_rd_inst0", 64'(bus.rd_inst0), 64'(mq[0].inst));
        end
        if (n >= 2) begin
            check("m_rd_pc1", 64'(bus.rd_pc1), 64'(mq[1].pc));
            check("m_rd_inst1", 64'(bus.rd_inst1), 64'(mq[1].inst));
        end
`ifdef INST_FIFO_PERF_CNT_EN
        check("m_stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
    endtask

    // Apply one clock edge of the specified queue behaviour to the model
    task automatic model_edge();
        int n;
        bit st;
        n  = mq.size();
        st = (DEPTH - n) < 2;
        if (st && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (fifo_flush) begin
            mq.delete();
        end else begin
            if (bus.rd_en0 && n >= 1) begin
                void'(mq.pop_front());
                if (bus.rd_en1 && n >= 2) void'(mq.pop_front());
            end
            if (!st && bus.wr_en0) begin
                mq.push_back('{pc: bus.wr_pc0, inst: bus.wr_inst0});
                if (bus.wr_en1) mq.push_back('{pc: bus.wr_pc1, inst: bus.wr_inst1});
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (resetn) model_edge();
        @(negedge clk);
        compare_model();
    endtask

    task automatic drive(input bit w0, input bit w1,
                         input logic [31:0] p0, input logic [31:0] i0,
                         input logic [31:0] p1, input logic [31:0] i1,
                         input bit r0, input bit r1, input bit fl);
        bus.wr_en0   = w0;
        bus.wr_en1   = w1;
        bus.wr_pc0   = p0;
        bus.wr_inst0 = i0;
        bus.wr_pc1   = p1;
        bus.wr_inst1 = i1;
        bus.rd_en0   = r0;
        bus.rd_en1   = r1;
        fifo_flush   = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once
    task automatic do_reset();
        #2 resetn = 1'b0;
        #1;
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_valid0", 64'(bus.rd_valid0), 64'd0);
        check("rst_valid1", 64'(bus.rd_valid1), 64'd0);
        check("rst_stall", 64'(bus.fifo_stall_req), 64'd0);
        mq.delete();
        m_stall = 0;
        @(negedge clk);
        resetn = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("init_count", 64'(bus.count), 64'd0);
        check("init_valid0", 64'(bus.rd_valid0), 64'd0);
        check("init_stall", 64'(bus.fifo_stall_req), 64'd0);
        resetn = 1'b1;

        // Dual push, then single pop
        drive(1, 1, 32'h100, 32'h11, 32'h104, 32'h22, 0, 0, 0);
        step();
        check("dual_count", 64'(bus.count), 64'd2);
        check("dual_pc0", 64'(bus.rd_pc0), 64'h100);
        check("dual_pc1", 64'(bus.rd_pc1), 64'h104);
        check("dual_inst0", 64'(bus.rd_inst0), 64'h11);
        check("dual_inst1", 64'(bus.rd_inst1), 64'h22);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        check("pop1_pc0", 64'(bus.rd_pc0), 64'h104);
        check("pop1_count", 64'(bus.count), 64'd1);
        check("pop1_valid1", 64'(bus.rd_valid1), 64'd0);

        // Reset mid-run with five entries queued
        drive(1, 1, 32'h110, 32'h33, 32'h114, 32'h44, 0, 0, 0);
        step();
        step();
        check("pre_rst_count", 64'(bus.count), 64'd5);
        do_reset();
        step();
        check("post_rst_count", 64'(bus.count), 64'd0);

        // Fill to full, then a dropped push alongside a dual pop
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 32'h1000 + 32'(8 * i), 32'hA0 + 32'(i), 32'h1004 + 32'(8 * i), 32'hB0 + 32'(i), 0, 0, 0);
            step();
        end
        check("full_count", 64'(bus.count), 64'd16);
        check("full_stall", 64'(bus.fifo_stall_req), 64'd1);
        drive(1, 1, 32'hDEAD, 32'h1, 32'hBEEF, 32'h2, 1, 1, 0);
        step();
        check("drop_count", 64'(bus.count), 64'd14);
        check("drop_stall", 64'(bus.fifo_stall_req), 64'd0);
        check("drop_pc0", 64'(bus.rd_pc0), 64'h1008);

        // Flush priority over same-cycle pushes and pops
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'h2000 + 32'(8 * i), 32'h5, 32'h2004 + 32'(8 * i), 32'h6, 0, 0, 0);
            step();
        end
        check("pre_flush_count", 64'(bus.count), 64'd6);
        drive(1, 1, 32'h3000, 32'h7, 32'h3004, 32'h8, 1, 1, 1);
        step();
        check("flush_count", 64'(bus.count), 64'd0);
        check("flush_valid0", 64'(bus.rd_valid0), 64'd0);
        idle();
        step();
        check("flush_nowrite", 64'(bus.count), 64'd0);

        // Walk head and tail to index 15 with the queue empty, then wrap
        for (int i = 0; i < 15; i++) begin
            drive(1, 0, 32'h400 + 32'(4 * i), 32'(i), 0, 0, 0, 0, 0);
            step();
            drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
            step();
        end
        check("wrap_empty", 64'(bus.count), 64'd0);
        drive(1, 1, 32'h200, 32'hAA, 32'h204, 32'hBB, 0, 0, 0);
        step();
        check("wrap_pc0", 64'(bus.rd_pc0), 64'h200);
        check("wrap_pc1", 64'(bus.rd_pc1), 64'h204);
        check("wrap_inst1", 64'(bus.rd_inst1), 64'hBB);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        check("wrap_pop_pc0", 64'(bus.rd_pc0), 64'h204);
        idle();

`ifdef INST_FIFO_PERF_CNT_EN
        // Full for ten stalled edges (nine idle plus the flush edge)
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 32'h5000 + 32'(8 * i), 32'h0, 32'h5004 + 32'(8 * i), 32'h0, 0, 0, 0);
            step();
        end
        check("perf_full", 64'(bus.count), 64'd16);
        check("perf_start", 64'(stall_cycles), 64'd0);
        idle();
        repeat (9) step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        check("perf_ten", 64'(stall_cycles), 64'd10);
        idle();
        step();
        check("perf_hold", 64'(stall_cycles), 64'd10);
`endif

        // Randomized traffic with varying push/pop pressure
        for (int ph = 0; ph < 6; ph++) begin
            int pw;
            int pr;
            pw = (ph % 3 == 0) ? 90 : ((ph % 3 == 1) ? 50 : 20);
            pr = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 50 : 90);
            for (int c = 0; c < 400; c++) begin
                bit w0, w1, r0, r1, fl;
                w0 = $urandom_range(0, 99) < pw;
                w1 = w0 && ($urandom_range(0, 1) == 1);
                r0 = $urandom_range(0, 99) < pr;
                r1 = r0 && ($urandom_range(0, 1) == 1);
                fl = ($urandom_range(0, 79) == 0);
                drive(w0, w1, $urandom, $urandom, $urandom, $urandom, r0, r1, fl);
                step();
            end
            if (ph == 3) do_reset();
        end

        idle();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fifo.md
Name: inst_fifo

Overview:
Dual-issue instruction queue between the fetch stage and the issue stage.
- Fetch pushes 0, 1 or 2 {pc, inst} pairs per cycle. Issue pops 0, 1 or 2 per cycle from a show-ahead head.
- Produces fifo_stall_req for the pipeline controller and consumes fifo_flush from it.
- Decouples I-cache latency from issue back-pressure and discards wrong-path instructions on branch or exception flush.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 4.
- PC_W, 32, PC width.
- INST_W, 32, instruction word width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- fifo_flush  in  1  synchronous flush of all entries; highest priority.
- wr_en0  in  1  push slot 0 this cycle.
- wr_en1  in  1  push slot 1 this cycle; legal only with wr_en0.
- wr_pc0  in  PC_W  PC of slot 0.
- wr_inst0  in  INST_W  instruction of slot 0.
- wr_pc1  in  PC_W  PC of slot 1.
- wr_inst1  in  INST_W  instruction of slot 1.
- rd_en0  in  1  issue consumes head entry.
- rd_en1  in  1  issue consumes head+1 entry; legal only with rd_en0.
- rd_valid0  out  1  head entry present.
- rd_pc0  out  PC_W  PC at head.
- rd_inst0  out  INST_W  instruction at head.
- rd_valid1  out  1  head+1 entry present.
- rd_pc1  out  PC_W  PC at head+1.
- rd_inst1  out  INST_W  instruction at head+1.
- fifo_stall_req  out  1  fewer than 2 free entries; fetch must hold.
- count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- State: head pointer, tail pointer (log2(DEPTH) bits each, natural wrap modulo DEPTH), count register, entry storage.
- Reset: resetn low asynchronously clears head, tail and count to 0.
  - Outputs while in reset: rd_valid0=0, rd_valid1=0, fifo_stall_req=0, count=0.
  - Storage contents are don't-care; rd_pc/rd_inst are not checked while rd_valid is low.
- Reads are show-ahead and combinational from registered state:
  - rd_valid0 = (count>=1), rd_valid1 = (count>=2).
  - rd_pc0/rd_inst0 come from entry[head]; rd_pc1/rd_inst1 come from entry[head+1 mod DEPTH].
- fifo_stall_req = (DEPTH - count) < 2; purely a function of registered count.
- Write acceptance: writes are accepted only when fifo_stall_req=0. Pops in the same cycle do not free space for that cycle's writes.
  - Accepted wr_en0 writes slot 0 to entry[tail].
  - Accepted wr_en1 writes slot 1 to entry[tail+1].
  - Tail advances by the number of accepted writes.
- Pop acceptance:
  - rd_en0 pops only if rd_valid0.
  - rd_en1 pops only if rd_en0, rd_valid0 and rd_valid1.
  - Head advances by the number of accepted pops.
- count_next = count + accepted writes - accepted pops. Simultaneous push and pop is legal at any occupancy that permits each individually.
- Illegal combinations are ignored:
  - wr_en1 without wr_en0 writes nothing.
  - rd_en1 without rd_en0 pops nothing.
  - Simulation-only assertion flags both cases.
- Flush: fifo_flush=1 sets head=tail=count=0 at the next edge. All same-cycle writes and pops are discarded. Outputs show empty the following cycle.
- Full boundary: at count=DEPTH-1 or DEPTH, stall is asserted and no write is accepted. Count never exceeds DEPTH.
- Empty boundary: at count=0, pops are ignored and count never underflows.
- Wrap-around: entries at index DEPTH-1 and 0 may be written in one cycle (tail=DEPTH-1, two pushes). Likewise head=DEPTH-1 reads entry[0] as head+1.
- Latency: a pushed entry is visible at the read port in the cycle after the push. There is no bypass.

Optional Feature:
Macro INST_FIFO_PERF_CNT_EN.
- Defined: adds output port stall_cycles (32 bits).
  - Counts cycles with fifo_stall_req=1 and saturates at 2^32-1.
  - Reset clears it to 0; fifo_flush does not clear it.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package/header holds the constants:
  - default DEPTH, PC_W, INST_W;
  - localparam PTR_W = log2(DEPTH);
  - localparam CNT_W = PTR_W + 1.
- One natural sub-module: inst_fifo_ram, a DEPTH-entry register file with 2 write ports and 2 combinational read ports, no reset on data.
- Pointer, count and acceptance logic stay in inst_fifo.

Test Plan:
- Reset then idle: resetn low mid-run with count=5 -> next cycle count=0, rd_valid0=0, rd_valid1=0, fifo_stall_req=0.
- Dual push then single pops: push {0x100,0x11},{0x104,0x22} -> next cycle count=2, rd_pc0=0x100, rd_pc1=0x104.
  - Then rd_en0 only -> rd_pc0=0x104, count=1, rd_valid1=0.
- Fill to full (DEPTH=16): 8 dual pushes -> count=16, fifo_stall_req=1.
  - A further dual push with rd_en0=rd_en1=1 -> push dropped, count=14, stall deasserts.
- Wrap-around: advance head and tail to 15 with count=0, dual push {0x200},{0x204} -> rd_pc0=0x200 from entry 15, rd_pc1=0x204 from entry 0.
- Flush priority: count=6, fifo_flush=1 with wr_en0/wr_en1 and rd_en0 all high -> next cycle count=0, rd_valid0=0, nothing written.
- INST_FIFO_PERF_CNT_EN defined: hold full for 10 cycles, then flush -> stall_cycles=10 and unchanged by the flush.
